sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares one single-port SRAM macro wrapper (`SramWrap`, 1024×32, per-bit write mask, 1-cycle read latency) between two requesters, e.g. fetch (p0) and load/store (p1). After reset it zero-fills the array, then arbitrates round-robin with a valid/ready handshake. Read data returns one cycle after acceptance with a response strobe. It sits directly above `SramWrap` and owns every SRAM control pin.

## Interface
- `BITS`, 32, data width
- `WORDS`, 1024, array depth
- `ADRESS_WIDTH`, 10, address width; `WORDS <= 2**ADRESS_WIDTH`
- `INIT_EN`, 1, 1 = zero-fill after reset; 0 = go straight to RUN
---
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous and active-low
- `pN_valid` in 1 (N=0,1): request present
- `pN_ready` out 1: request accepted this cycle when `pN_valid & pN_ready`
- `pN_wen` in 1: 1 = write, 0 = read
- `pN_adress` in ADRESS_WIDTH: word address
- `pN_din` in BITS: write data
- `pN_mask` in BITS: per-bit write mask, 0 = bit written (SRAM WEB convention)
- `pN_rsp_valid` out 1: read data valid on `rsp_dout`
- `rsp_dout` out BITS: shared read data
- `init_done` out 1: high once RUN is reached
- `sram_cen` out 1: chip enable, active-low
- `sram_wen` out 1: 1 = write
- `sram_adress` out ADRESS_WIDTH; `sram_din` out BITS; `sram_mask` out BITS
- `sram_dout` in BITS: macro read data

## Operation
- FSM states:
  - INIT: counter `init_adr` runs 0..WORDS-1. Each cycle drives `sram_cen=0`, `sram_wen=1`, `sram_mask='0`, `sram_din='0`. Both `pN_ready=0`.
  - After address WORDS-1 is written → RUN. `init_done` rises the next cycle and stays high.
  - INIT_EN=0: reset goes straight to RUN.
- RUN arbitration: one grant per cycle. Readies are combinational from the valids and the `last` register.
  - Only one port valid → that port is granted.
  - Both valid → the port ≠ `last` is granted.
  - `last` updates only on an accepted request. Reset value of `last` is 1, so p0 wins the first tie.
  - `ready` is never asserted to a port whose valid is low.
- Granted request drives the SRAM combinationally in the same cycle: `sram_cen=0`, plus the winner's wen/adress/din/mask. No grant → `sram_cen=1`, other SRAM outputs hold 0.
- Reads: a registered tag (`rd_pend`, `rd_port`) asserts `pN_rsp_valid` for exactly one cycle, one cycle after acceptance. `rsp_dout = sram_dout` passes through unregistered.
- Writes get no response.
- No backpressure on responses. Requesters must sink `rsp_valid`.
- Reset values: `pN_ready=0`, `pN_rsp_valid=0`, `init_done=0`, `sram_cen=1`, state=INIT (RUN if INIT_EN=0), `init_adr=0`, `rd_pend=0`.
- Reset mid-INIT restarts the fill at address 0. Reset mid-RUN drops any pending read response, so no `rsp_valid` follows reset.

## Timing
- Cycle t: valid&ready → SRAM samples at end of t. Read: `pN_rsp_valid`/`rsp_dout` valid in t+1.
- Back-to-back accepts every cycle. Throughput is 1 access/cycle total.
- Both ports continuously valid → grants alternate p0,p1,p0,…
- Write at t, read of the same address at t+1 → response at t+2 returns the new data (macro write-through not required).
- Read at t and accept at t+1 → the t read's response (t+1) and the t+1 access overlap; the tag register is updated every cycle.
- INIT takes exactly WORDS cycles after `rst_n` deasserts. First possible accept is cycle WORDS. `init_done` is high from cycle WORDS+1.

## Structure
- `sram_ctrl_pkg`: state enum {INIT, RUN}, default BITS/WORDS/ADRESS_WIDTH constants, request struct (wen, adress, din, mask).
- Sub-module `sram_rr_arb2`: 2-way round-robin arbiter with inputs `clk`, `rst_n`, `req[1:0]`, `accept` and outputs `gnt[1:0]` (one-hot or zero), `last`.
- Top holds the FSM, init counter, SRAM mux and read tag. `SramWrap` is instantiated outside this block.

## Test plan
- Reset, INIT_EN=1, WORDS=1024: `sram_cen=0` with mask 0 for 1024 cycles, addresses 0..1023; `init_done` rises at cycle 1025; no ready during INIT. Then read addr 0x3FF → `rsp_dout=0`.
- p0 writes 0xDEADBEEF to addr 5 with mask 0, then reads addr 5 next cycle → `p0_rsp_valid` 1 cycle later with 0xDEADBEEF, `p1_rsp_valid=0`.
- Masked write 0x0000FFFF to addr 5 with mask 0xFFFF0000 → next read returns 0xDEADFFFF.
- Both ports hold valid reads (p0 addr 1, p1 addr 2) for 6 cycles → grants p0,p1,p0,p1,p0,p1; each rsp_valid is tagged to the correct port with the matching data.
- Accept a p1 read, then assert `rst_n=0` the next cycle → no `p1_rsp_valid`; FSM back in INIT at address 0.
- Idle cycles with no valid → `sram_cen=1`, no responses.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and default geometry for the two-port SRAM arbiter.
package sram_ctrl_pkg;

  localparam int DEF_BITS         = 32;
  localparam int DEF_WORDS        = 1024;
  localparam int DEF_ADRESS_WIDTH = 10;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                        wen;
    logic [DEF_ADRESS_WIDTH-1:0] adress;
    logic [DEF_BITS-1:0]         din;
    logic [DEF_BITS-1:0]         mask;
  } req_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Per-requester handshake bundle: request fields in, ready and read strobe back.
interface sram_arbiter_if #(
  parameter int BITS         = sram_ctrl_pkg::DEF_BITS,
  parameter int ADRESS_WIDTH = sram_ctrl_pkg::DEF_ADRESS_WIDTH
) ();

  logic                    valid;
  logic                    ready;
  logic                    wen;
  logic [ADRESS_WIDTH-1:0] adress;
  logic [BITS-1:0]         din;
  logic [BITS-1:0]         mask;
  logic                    rsp_valid;

  modport master (
    output valid, wen, adress, din, mask,
    input  ready, rsp_valid
  );

  modport slave (
    input  valid, wen, adress, din, mask,
    output ready, rsp_valid
  );

endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the port that did not win last goes first.
module sram_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       last
);

  logic last_q;

  // Grant selection: single requester wins outright, a tie goes to the port != last.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Last-winner register, moves only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt[1];
    end else begin
      last_q <= last_q;
    end
  end

  assign last = last_q;

endmodule

// File: rtl/sram_arbiter.sv
// Owns the SRAM control pins: zero-fills the array after reset, then shares it
// round-robin between two requesters and tags read responses back to the winner.
module sram_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int BITS         = DEF_BITS,
  parameter int WORDS        = DEF_WORDS,
  parameter int ADRESS_WIDTH = DEF_ADRESS_WIDTH,
  parameter int INIT_EN      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sram_arbiter_if.slave           p0,
  sram_arbiter_if.slave           p1,
  output logic [BITS-1:0]         rsp_dout,
  output logic                    init_done,
  output logic                    sram_cen,
  output logic                    sram_wen,
  output logic [ADRESS_WIDTH-1:0] sram_adress,
  output logic [BITS-1:0]         sram_din,
  output logic [BITS-1:0]         sram_mask,
  input  logic [BITS-1:0]         sram_dout
);

  localparam state_t                  RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADRESS_WIDTH-1:0] LAST_ADR  = ADRESS_WIDTH'(WORDS - 1);

  state_t                  state_q, state_d;
  logic [ADRESS_WIDTH-1:0] init_adr_q, init_adr_d;
  logic                    init_done_q;
  logic                    rd_pend_q;

  logic       run_s;
  logic       init_s;
  logic [1:0] req_s;
  logic [1:0] gnt_s;
  logic       accept_s;
  logic       win_wen_s;
  logic       rd_port_s;

  // Pins are quiet while rst_n is low so nothing reaches the macro during reset.
  assign run_s  = rst_n & (state_q == ST_RUN);
  assign init_s = rst_n & (state_q == ST_INIT);
  assign req_s  = {p1.valid, p0.valid} & {2{run_s}};

  sram_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_s),
    .accept (accept_s),
    .gnt    (gnt_s),
    .last   (rd_port_s)
  );

  assign accept_s  = |gnt_s;
  assign win_wen_s = gnt_s[1] ? p1.wen : p0.wen;
  assign p0.ready  = gnt_s[0];
  assign p1.ready  = gnt_s[1];

  // last always names the most recent accepted port, so it doubles as the read tag.
  assign p0.rsp_valid = rst_n & rd_pend_q & ~rd_port_s;
  assign p1.rsp_valid = rst_n & rd_pend_q &  rd_port_s;
  assign rsp_dout     = sram_dout;
  assign init_done    = init_done_q;

  // SRAM pin mux: fill writes during INIT, otherwise the granted request.
  always_comb begin
    sram_cen    = 1'b1;
    sram_wen    = 1'b0;
    sram_adress = '0;
    sram_din    = '0;
    sram_mask   = '0;
    if (init_s) begin
      sram_cen    = 1'b0;
      sram_wen    = 1'b1;
      sram_adress = init_adr_q;
    end else if (gnt_s[0]) begin
      sram_cen    = 1'b0;
      sram_wen    = p0.wen;
      sram_adress = p0.adress;
      sram_din    = p0.din;
      sram_mask   = p0.mask;
    end else if (gnt_s[1]) begin
      sram_cen    = 1'b0;
      sram_wen    = p1.wen;
      sram_adress = p1.adress;
      sram_din    = p1.din;
      sram_mask   = p1.mask;
    end else begin
      sram_cen = 1'b1;
    end
  end

  // Next-state logic for the fill counter and INIT -> RUN transition.
  always_comb begin
    state_d    = state_q;
    init_adr_d = init_adr_q;
    case (state_q)
      ST_INIT: begin
        if (init_adr_q == LAST_ADR) begin
          state_d = ST_RUN;
        end else begin
          init_adr_d = init_adr_q + ADRESS_WIDTH'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d    = RST_STATE;
        init_adr_d = '0;
      end
    endcase
  end

  // FSM, fill counter, init_done flag and read-pending tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      init_adr_q  <= '0;
      init_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_adr_q  <= init_adr_d;
      init_done_q <= (state_q == ST_RUN);
      rd_pend_q   <= accept_s & ~win_wen_s;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 1-cycle-latency masked SRAM.
module tb_sram_arbiter;
  import sram_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] rsp_dout;
  logic        init_done;
  logic        sram_cen;
  logic        sram_wen;
  logic [9:0]  sram_adress;
  logic [31:0] sram_din;
  logic [31:0] sram_mask;
  logic [31:0] sram_dout;

  logic [31:0] mem [0:1023];

  int tests;
  int fails;

  sram_arbiter_if #(.BITS(32), .ADRESS_WIDTH(10)) p0_if ();
  sram_arbiter_if #(.BITS(32), .ADRESS_WIDTH(10)) p1_if ();

  sram_arbiter #(
    .BITS(32), .WORDS(1024), .ADRESS_WIDTH(10), .INIT_EN(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p0          (p0_if),
    .p1          (p1_if),
    .rsp_dout    (rsp_dout),
    .init_done   (init_done),
    .sram_cen    (sram_cen),
    .sram_wen    (sram_wen),
    .sram_adress (sram_adress),
    .sram_din    (sram_din),
    .sram_mask   (sram_mask),
    .sram_dout   (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: mask bit 0 means the bit is written; reads return one cycle later.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (sram_wen) begin
        mem[sram_adress] <= (mem[sram_adress] & sram_mask) | (sram_din & ~sram_mask);
      end else begin
        sram_dout <= mem[sram_adress];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v0, input req_t r0, input logic v1, input req_t r1);
    p0_if.valid  = v0;
    p0_if.wen    = r0.wen;
    p0_if.adress = r0.adress;
    p0_if.din    = r0.din;
    p0_if.mask   = r0.mask;
    p1_if.valid  = v1;
    p1_if.wen    = r1.wen;
    p1_if.adress = r1.adress;
    p1_if.din    = r1.din;
    p1_if.mask   = r1.mask;
  endtask

  function automatic req_t mk(input logic w, input logic [9:0] a, input logic [31:0] d,
                              input logic [31:0] m);
    req_t r;
    r.wen = w; r.adress = a; r.din = d; r.mask = m;
    return r;
  endfunction

  task automatic test_reset();
    int bad;
    req_t rd3ff;
    rd3ff = mk(1'b0, 10'h3FF, 32'h0, 32'h0);
    bad = 0;
    rst_n = 1'b0;
    drive(1'b1, rd3ff, 1'b1, rd3ff);
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (sram_cen !== 1'b1 || p0_if.ready !== 1'b0 || p1_if.ready !== 1'b0 ||
        init_done !== 1'b0 || p0_if.rsp_valid !== 1'b0 || p1_if.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: cen=%b rdy=%b%b done=%b rsp=%b%b, required cen=1 rest 0",
               sram_cen, p1_if.ready, p0_if.ready, init_done, p1_if.rsp_valid, p0_if.rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      #1;
      if (sram_cen !== 1'b0 || sram_wen !== 1'b1 || sram_adress !== 10'(i) ||
          sram_din !== 32'h0 || sram_mask !== 32'h0 || p0_if.ready !== 1'b0 ||
          p1_if.ready !== 1'b0 || init_done !== 1'b0) begin
        bad++;
      end
      @(negedge clk);
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL init_fill: %0d bad fill cycles, required 0", bad);
    end
    #1;
    tests++;
    if (p0_if.ready !== 1'b1 || p1_if.ready !== 1'b0 || init_done !== 1'b0 ||
        sram_adress !== 10'h3FF || sram_wen !== 1'b0 || sram_cen !== 1'b0) begin
      fails++;
      $display("FAIL first_accept: rdy=%b%b done=%b adr=%h wen=%b cen=%b, required rdy=01 done=0 adr=3ff wen=0 cen=0",
               p1_if.ready, p0_if.ready, init_done, sram_adress, sram_wen, sram_cen);
    end
    @(negedge clk);
    #1;
    tests++;
    if (init_done !== 1'b1 || p0_if.rsp_valid !== 1'b1 || p1_if.rsp_valid !== 1'b0 ||
        rsp_dout !== 32'h0 || p1_if.ready !== 1'b1 || p0_if.ready !== 1'b0) begin
      fails++;
      $display("FAIL init_done_rsp: done=%b rsp=%b%b dout=%h rdy=%b%b, required done=1 rsp=01 dout=0 rdy=10",
               init_done, p1_if.rsp_valid, p0_if.rsp_valid, rsp_dout, p1_if.ready, p0_if.ready);
    end
    @(negedge clk);
    drive(1'b0, rd3ff, 1'b0, rd3ff);
    #1;
    tests++;
    if (p1_if.rsp_valid !== 1'b1 || p0_if.rsp_valid !== 1'b0 || rsp_dout !== 32'h0 ||
        sram_cen !== 1'b1) begin
      fails++;
      $display("FAIL p1_zero_read: rsp=%b%b dout=%h cen=%b, required rsp=10 dout=0 cen=1",
               p1_if.rsp_valid, p0_if.rsp_valid, rsp_dout, sram_cen);
    end
  endtask

  task automatic test_write_read(input logic [31:0] wdata, input logic [31:0] wmask,
                                 input logic [31:0] exp_data);
    req_t idle;
    idle = mk(1'b0, 10'h0, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, mk(1'b1, 10'd5, wdata, wmask), 1'b0, idle);
    #1;
    tests++;
    if (p0_if.ready !== 1'b1 || sram_wen !== 1'b1 || sram_adress !== 10'd5 ||
        sram_din !== wdata || sram_mask !== wmask) begin
      fails++;
      $display("FAIL write_drive: rdy=%b wen=%b adr=%h din=%h mask=%h, required rdy=1 wen=1 adr=005 din=%h mask=%h",
               p0_if.ready, sram_wen, sram_adress, sram_din, sram_mask, wdata, wmask);
    end
    @(negedge clk);
    drive(1'b1, mk(1'b0, 10'd5, 32'h0, 32'h0), 1'b0, idle);
    #1;
    tests++;
    if (p0_if.ready !== 1'b1 || sram_wen !== 1'b0 || p0_if.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL read_accept: rdy=%b wen=%b rsp=%b, required rdy=1 wen=0 rsp=0 (writes have no response)",
               p0_if.ready, sram_wen, p0_if.rsp_valid);
    end
    @(negedge clk);
    drive(1'b0, idle, 1'b0, idle);
    #1;
    tests++;
    if (p0_if.rsp_valid !== 1'b1 || p1_if.rsp_valid !== 1'b0 || rsp_dout !== exp_data) begin
      fails++;
      $display("FAIL read_data: rsp=%b%b dout=%h, required rsp=01 dout=%h",
               p1_if.rsp_valid, p0_if.rsp_valid, rsp_dout, exp_data);
    end
  endtask

  task automatic test_round_robin();
    req_t idle;
    logic exp1;
    logic prev1;
    idle = mk(1'b0, 10'h0, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, mk(1'b1, 10'd1, 32'h1111_1111, 32'h0), 1'b0, idle);
    @(negedge clk);
    drive(1'b0, idle, 1'b1, mk(1'b1, 10'd2, 32'h2222_2222, 32'h0));
    #1;
    tests++;
    if (p1_if.ready !== 1'b1 || p0_if.ready !== 1'b0) begin
      fails++;
      $display("FAIL p1_write_grant: rdy=%b%b, required 10", p1_if.ready, p0_if.ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(1'b1, mk(1'b0, 10'd1, 32'h0, 32'h0), 1'b1, mk(1'b0, 10'd2, 32'h0, 32'h0));
      #1;
      exp1 = k[0];
      tests++;
      if (p0_if.ready !== ~exp1 || p1_if.ready !== exp1 ||
          sram_adress !== (exp1 ? 10'd2 : 10'd1)) begin
        fails++;
        $display("FAIL rr_grant[%0d]: rdy=%b%b adr=%h, required rdy=%b%b adr=%0d",
                 k, p1_if.ready, p0_if.ready, sram_adress, exp1, ~exp1, exp1 ? 2 : 1);
      end
      if (k == 0) begin
        tests++;
        if (p0_if.rsp_valid !== 1'b0 || p1_if.rsp_valid !== 1'b0) begin
          fails++;
          $display("FAIL rr_no_rsp: rsp=%b%b, required 00", p1_if.rsp_valid, p0_if.rsp_valid);
        end
      end else begin
        prev1 = ~exp1;
        tests++;
        if (p0_if.rsp_valid !== ~prev1 || p1_if.rsp_valid !== prev1 ||
            rsp_dout !== (prev1 ? 32'h2222_2222 : 32'h1111_1111)) begin
          fails++;
          $display("FAIL rr_rsp[%0d]: rsp=%b%b dout=%h, required rsp=%b%b dout=%h",
                   k, p1_if.rsp_valid, p0_if.rsp_valid, rsp_dout, prev1, ~prev1,
                   prev1 ? 32'h2222_2222 : 32'h1111_1111);
        end
      end
    end
    @(negedge clk);
    drive(1'b0, idle, 1'b0, idle);
    #1;
    tests++;
    if (p1_if.rsp_valid !== 1'b1 || p0_if.rsp_valid !== 1'b0 || rsp_dout !== 32'h2222_2222) begin
      fails++;
      $display("FAIL rr_last_rsp: rsp=%b%b dout=%h, required rsp=10 dout=22222222",
               p1_if.rsp_valid, p0_if.rsp_valid, rsp_dout);
    end
  endtask

  task automatic test_idle();
    req_t idle;
    idle = mk(1'b0, 10'h0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b0, idle, 1'b0, idle);
      #1;
      tests++;
      if (sram_cen !== 1'b1 || sram_wen !== 1'b0 || sram_adress !== 10'h0 ||
          sram_din !== 32'h0 || sram_mask !== 32'h0 || p0_if.rsp_valid !== 1'b0 ||
          p1_if.rsp_valid !== 1'b0 || p0_if.ready !== 1'b0 || p1_if.ready !== 1'b0) begin
        fails++;
        $display("FAIL idle[%0d]: cen=%b wen=%b adr=%h rsp=%b%b rdy=%b%b, required cen=1 all others 0",
                 k, sram_cen, sram_wen, sram_adress, p1_if.rsp_valid, p0_if.rsp_valid,
                 p1_if.ready, p0_if.ready);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    req_t idle;
    req_t rd2;
    idle = mk(1'b0, 10'h0, 32'h0, 32'h0);
    rd2  = mk(1'b0, 10'd2, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, idle, 1'b1, rd2);
    #1;
    tests++;
    if (p1_if.ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_run_accept: p1_ready=%b, required 1", p1_if.ready);
    end
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, idle, 1'b0, idle);
    #1;
    tests++;
    if (p1_if.rsp_valid !== 1'b0 || p0_if.rsp_valid !== 1'b0 || sram_cen !== 1'b1) begin
      fails++;
      $display("FAIL rsp_dropped: rsp=%b%b cen=%b, required rsp=00 cen=1",
               p1_if.rsp_valid, p0_if.rsp_valid, sram_cen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, idle, 1'b1, rd2);
    #1;
    tests++;
    if (sram_cen !== 1'b0 || sram_wen !== 1'b1 || sram_adress !== 10'h0 || init_done !== 1'b0 ||
        p1_if.ready !== 1'b0 || p1_if.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reinit_adr0: cen=%b wen=%b adr=%h done=%b rdy=%b rsp=%b, required cen=0 wen=1 adr=000 done=0 rdy=0 rsp=0",
               sram_cen, sram_wen, sram_adress, init_done, p1_if.ready, p1_if.rsp_valid);
    end
    @(negedge clk);
    #1;
    tests++;
    if (sram_adress !== 10'h1 || sram_cen !== 1'b0 || p1_if.ready !== 1'b0 ||
        p1_if.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reinit_adr1: adr=%h cen=%b rdy=%b rsp=%b, required adr=001 cen=0 rdy=0 rsp=0",
               sram_adress, sram_cen, p1_if.ready, p1_if.rsp_valid);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    sram_dout = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_5A5A;
    test_reset();
    test_write_read(32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF);
    test_write_read(32'h0000_FFFF, 32'hFFFF_0000, 32'hDEAD_FFFF);
    test_round_robin();
    test_idle();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
